// File: rtl/dram_pkg.sv
// Shared encodings and helpers for the data RAM slave: load/store sizes,
// FSM state type and the byte-enable decoder.
package dram_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} dram_state_e;

  // Byte enables for a store; H ignores addr[0], W ignores addr[1:0].
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      SIZE_B, SIZE_BU: m = 4'b0001 << addr;
      SIZE_H, SIZE_HU: m = addr[1] ? 4'b1100 : 4'b0011;
      default:         m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dram_load_fmt.sv
// Load formatter: selects the addressed byte/half of a RAM word and
// sign- or zero-extends it according to the RV32I load size.
module dram_load_fmt
  import dram_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  size,
  input  logic [1:0]  addr,
  output logic [31:0] ext
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign shifted = word >> {addr, 3'b000};
  assign b       = shifted[7:0];
  assign h       = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    ext = word;
    case (size)
      SIZE_B:  ext = {{24{b[7]}}, b};
      SIZE_BU: ext = {24'h0, b};
      SIZE_H:  ext = {{16{h[15]}}, h};
      SIZE_HU: ext = {16'h0, h};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/data_ram_slave.sv
// Data-port responder: word RAM with byte-lane stores, 1-cycle formatted loads
// and a wait-state FSM. Define DRAM_MISALIGN_CHK_EN to trap misaligned W/H accesses.
module data_ram_slave
  import dram_pkg::*;
#(
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_we_i,
  input  logic        data_re_i,
  input  logic [2:0]  data_size_i,
  output logic [31:0] data_rdata_o,
  output logic        hold_flag_o
`ifdef DRAM_MISALIGN_CHK_EN
  ,
  output logic        err_o,
  output logic [31:0] err_addr_o
`endif
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [3:0] WS_M1    = 4'(WAIT_STATES - 1);

  logic [31:0] mem [DEPTH];

  dram_state_e state;
  logic [3:0]  cnt;
  logic        req, perform, in_range, mis;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wdata_rep, ram_word, load_val;

  assign req      = data_we_i | data_re_i;
  assign idx      = data_addr_i[AW+1:2];
  assign in_range = (data_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign be       = lane_mask(data_size_i, data_addr_i[1:0]);
  assign ram_word = mem[idx];

`ifdef DRAM_MISALIGN_CHK_EN
  assign mis = (data_size_i[1:0] == 2'b10 && data_addr_i[1:0] != 2'b00) ||
               (data_size_i[1:0] == 2'b01 && data_addr_i[0]);
`else
  assign mis = 1'b0;
`endif

  // Replicating the store data lets the byte enables pick the right lanes.
  always_comb begin
    wdata_rep = data_wdata_i;
    case (data_size_i[1:0])
      2'b00:   wdata_rep = {4{data_wdata_i[7:0]}};
      2'b01:   wdata_rep = {2{data_wdata_i[15:0]}};
      default: wdata_rep = data_wdata_i;
    endcase
  end

  assign hold_flag_o = !rst && req && ((state == IDLE) ? HAS_WAIT : (cnt != 4'd0));
  assign perform     = !rst && req && ((state == IDLE) ? !HAS_WAIT : (cnt == 4'd0));

  dram_load_fmt u_fmt (
    .word (ram_word),
    .size (data_size_i),
    .addr (data_addr_i[1:0]),
    .ext  (load_val)
  );

  always_ff @(posedge clk) begin
    if (perform && data_we_i && in_range && !mis) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      data_rdata_o <= 32'h0;
    end else begin
      if (perform && data_re_i && !data_we_i)
        data_rdata_o <= (in_range && !mis) ? load_val : 32'h0;
      case (state)
        IDLE: if (req && HAS_WAIT) begin
          state <= WAIT;
          cnt   <= WS_M1;
        end
        WAIT: begin
          if (!req || cnt == 4'd0) state <= IDLE;
          else                     cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAM_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o      <= 1'b0;
      err_addr_o <= 32'h0;
    end else begin
      err_o <= perform && mis;
      if (perform && mis) err_addr_o <= data_addr_i;
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_slave.sv
// Directed bench for data_ram_slave: zero-wait and 3-wait-state instances
// sharing one clock and reset.
module tb_data_ram_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a0, wd0, rd0, a3, wd3, rd3;
  logic        we0, re0, h0, we3, re3, h3;
  logic [2:0]  sz0, sz3;
`ifdef DRAM_MISALIGN_CHK_EN
  logic        err0, err3;
  logic [31:0] ea0, ea3;
`endif

  int checks = 0;
  int errors = 0;

  data_ram_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .data_addr_i(a0), .data_wdata_i(wd0), .data_we_i(we0),
    .data_re_i(re0), .data_size_i(sz0), .data_rdata_o(rd0), .hold_flag_o(h0)
`ifdef DRAM_MISALIGN_CHK_EN
    , .err_o(err0), .err_addr_o(ea0)
`endif
  );

  data_ram_slave #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .data_addr_i(a3), .data_wdata_i(wd3), .data_we_i(we3),
    .data_re_i(re3), .data_size_i(sz3), .data_rdata_o(rd3), .hold_flag_o(h3)
`ifdef DRAM_MISALIGN_CHK_EN
    , .err_o(err3), .err_addr_o(ea3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait access: present on a negedge, perform on the next posedge.
  task automatic op0(input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic re, input logic [2:0] sz);
    @(negedge clk);
    a0 = a; wd0 = wd; we0 = we; re0 = re; sz0 = sz;
    #1 chk("hold0_low", {31'b0, h0}, 32'h0);
    @(posedge clk);
    #1 we0 = 1'b0; re0 = 1'b0;
  endtask

  // Three-wait access held stable: hold in cycles 0..2, perform in cycle 3.
  task automatic op3(input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic re, input logic [2:0] sz, input logic [31:0] prev);
    @(negedge clk);
    a3 = a; wd3 = wd; we3 = we; re3 = re; sz3 = sz;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("hold3_c%0d", c), {31'b0, h3}, (c < 3) ? 32'h1 : 32'h0);
      if (c == 3) chk("rd3_before_perform", rd3, prev);
      else        @(negedge clk);
    end
    @(posedge clk);
    #1 we3 = 1'b0; re3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a0 = '0; wd0 = '0; we0 = 0; re0 = 0; sz0 = 3'b010;
    a3 = '0; wd3 = '0; we3 = 0; re3 = 0; sz3 = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_h0", {31'b0, h0}, 32'h0);
    chk("rst_rd3", rd3, 32'h0);
    chk("rst_h3", {31'b0, h3}, 32'h0);
`ifdef DRAM_MISALIGN_CHK_EN
    chk("rst_err0", {31'b0, err0}, 32'h0);
    chk("rst_ea0", ea0, 32'h0);
`endif
    @(negedge clk) rst = 1'b0;

    // Word store/load
    op0(32'h1000_0004, 32'hDEAD_BEEF, 1, 0, 3'b010);
    op0(32'h1000_0004, 32'h0, 0, 1, 3'b010);
    chk("lw_04", rd0, 32'hDEAD_BEEF);

    // Byte store into a word, then byte loads
    op0(32'h1000_0008, 32'h1122_3344, 1, 0, 3'b010);
    op0(32'h1000_0009, 32'h0000_0080, 1, 0, 3'b000);
    op0(32'h1000_0008, 32'h0, 0, 1, 3'b010);
    chk("lw_after_sb", rd0, 32'h1122_8044);
    op0(32'h1000_0009, 32'h0, 0, 1, 3'b000);
    chk("lb_09", rd0, 32'hFFFF_FF80);
    op0(32'h1000_0009, 32'h0, 0, 1, 3'b100);
    chk("lbu_09", rd0, 32'h0000_0080);

    // Half store into upper half, lower half preserved
    op0(32'h1000_000C, 32'h5566_7788, 1, 0, 3'b010);
    op0(32'h1000_000E, 32'h0000_BEEF, 1, 0, 3'b001);
    op0(32'h1000_000E, 32'h0, 0, 1, 3'b001);
    chk("lh_0e", rd0, 32'hFFFF_BEEF);
    op0(32'h1000_000E, 32'h0, 0, 1, 3'b101);
    chk("lhu_0e", rd0, 32'h0000_BEEF);
    op0(32'h1000_000C, 32'h0, 0, 1, 3'b010);
    chk("lw_after_sh", rd0, 32'hBEEF_7788);

    // Out of range: store dropped, load returns 0, word 0 untouched
    op0(32'h1000_0000, 32'h0123_4567, 1, 0, 3'b010);
    op0(32'h2000_0000, 32'hCAFE_F00D, 1, 0, 3'b010);
    op0(32'h2000_0000, 32'h0, 0, 1, 3'b010);
    chk("lw_oor", rd0, 32'h0);
    op0(32'h1000_0000, 32'h0, 0, 1, 3'b010);
    chk("lw_word0", rd0, 32'h0123_4567);

    // we and re together: a write, read data holds
    op0(32'h1000_0010, 32'hAAAA_5555, 1, 1, 3'b010);
    chk("we_re_hold", rd0, 32'h0123_4567);
    op0(32'h1000_0010, 32'h0, 0, 1, 3'b010);
    chk("lw_10", rd0, 32'hAAAA_5555);
    @(posedge clk);
    #1 chk("idle_hold", rd0, 32'hAAAA_5555);

`ifdef DRAM_MISALIGN_CHK_EN
    op0(32'h1000_0002, 32'h0, 0, 1, 3'b010);
    chk("mis_lw_rd", rd0, 32'h0);
    chk("mis_lw_err", {31'b0, err0}, 32'h1);
    chk("mis_lw_ea", ea0, 32'h1000_0002);
    @(posedge clk);
    #1 chk("mis_err_pulse", {31'b0, err0}, 32'h0);
    op0(32'h1000_0001, 32'h0000_7777, 1, 0, 3'b001);
    chk("mis_sh_err", {31'b0, err0}, 32'h1);
    op0(32'h1000_0000, 32'h0, 0, 1, 3'b010);
    chk("mis_sh_nowrite", rd0, 32'h0123_4567);
    chk("mis_ok_noerr", {31'b0, err0}, 32'h0);
`else
    op0(32'h1000_0006, 32'h0, 0, 1, 3'b010);
    chk("lw_align", rd0, 32'hDEAD_BEEF);
    op0(32'h1000_000F, 32'h0, 0, 1, 3'b101);
    chk("lhu_align", rd0, 32'h0000_BEEF);
`endif

    // Wait-state instance
    op3(32'h1000_0020, 32'h0BAD_F00D, 1, 0, 3'b010, 32'h0);
    op3(32'h1000_0020, 32'h0, 0, 1, 3'b010, 32'h0);
    chk("ws_lw_20", rd3, 32'h0BAD_F00D);
    op3(32'h1000_0024, 32'h1234_5678, 1, 0, 3'b010, 32'h0BAD_F00D);

    // Abort: drop re in cycle 1
    @(negedge clk);
    a3 = 32'h1000_0024; re3 = 1'b1; sz3 = 3'b010;
    #1 chk("abort_c0_hold", {31'b0, h3}, 32'h1);
    @(negedge clk) re3 = 1'b0;
    #1 chk("abort_c1_hold", {31'b0, h3}, 32'h0);
    @(posedge clk);
    #1 chk("abort_no_update", rd3, 32'h0BAD_F00D);
    op3(32'h1000_0024, 32'h0, 0, 1, 3'b010, 32'h0BAD_F00D);
    chk("ws_lw_24", rd3, 32'h1234_5678);

    // Reset during the wait of a store: store never commits
    @(negedge clk);
    a3 = 32'h1000_0024; wd3 = 32'hFFFF_FFFF; we3 = 1'b1; sz3 = 3'b010;
    #1 chk("rstwait_hold", {31'b0, h3}, 32'h1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; we3 = 1'b0;
    #1;
    chk("rstwait_h3", {31'b0, h3}, 32'h0);
    chk("rstwait_rd3", rd3, 32'h0);
    op3(32'h1000_0024, 32'h0, 0, 1, 3'b010, 32'h0);
    chk("rstwait_nocommit", rd3, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
